// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory handshake from the EX/MEM register,
// stalls upstream until the access completes, and builds the MEM/WB write-back word.
module mem_stage #(
  parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [138:0] EX_MEM,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         mem_stall,
  output logic [4:0]   EX_MEM_Rd,
  output logic [31:0]  EX_MEM_RdData,
  output logic         EX_MEM_RegWrite,
  output logic [37:0]  MEM_WB,
  output logic [4:0]   MEM_WB_Rd,
  output logic [31:0]  MEM_WB_RdData,
  output logic         MEM_WB_RegWrite,
  output logic         bus_error,
  output logic         misalign
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;

  logic [31:0] store_data, alu_res, pc_plus4, lu_data;
  logic [4:0]  write_reg;
  logic        mem_read, mem_write, reg_write, lu_op;
  logic [1:0]  mem_to_reg;

  logic        access, aligned, misal, timeout, done;
  logic [31:0] rdata_eff, wb_data;
  logic        reg_write_eff;

  // Write-back mux shared by the registered path and the forwarding view.
  function automatic logic [31:0] wb_sel(input logic        luop,
                                         input logic [1:0]  mtr,
                                         input logic [31:0] alu,
                                         input logic [31:0] rdata,
                                         input logic [31:0] pc4,
                                         input logic [31:0] lud);
    logic [31:0] r;
    if (luop) begin
      r = lud;
    end else begin
      case (mtr)
        2'b00:   r = alu;
        2'b01:   r = rdata;
        2'b10:   r = pc4;
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  assign store_data = EX_MEM[31:0];
  assign alu_res    = EX_MEM[63:32];
  assign write_reg  = EX_MEM[68:64];
  assign mem_read   = EX_MEM[69];
  assign mem_write  = EX_MEM[70];
  assign reg_write  = EX_MEM[71];
  assign mem_to_reg = EX_MEM[73:72];
  assign pc_plus4   = EX_MEM[105:74];
  assign lu_data    = EX_MEM[137:106];
  assign lu_op      = EX_MEM[138];

  assign access  = mem_read | mem_write;
  assign aligned = (alu_res[1:0] == 2'b00);
  assign misal   = access & ~aligned;
  // An ack arriving on the timeout cycle still counts as a good completion.
  assign timeout = (state == WAIT) & (cnt == ACK_TIMEOUT) & ~mem_ack;
  assign done    = mem_ack | timeout | misal;

  assign mem_req   = access & aligned;
  assign mem_we    = mem_write;
  assign mem_addr  = alu_res;
  assign mem_wdata = store_data;
  assign mem_stall = access & ~done;

  assign rdata_eff     = mem_ack ? mem_rdata : 32'h0;
  assign wb_data       = wb_sel(lu_op, mem_to_reg, alu_res, rdata_eff, pc_plus4, lu_data);
  assign reg_write_eff = reg_write & ~timeout & ~misal;

  // Loads are not forwardable here, so the read-data leg falls back to the ALU result.
  assign EX_MEM_Rd       = write_reg;
  assign EX_MEM_RegWrite = reg_write & ~mem_read;
  assign EX_MEM_RdData   = wb_sel(lu_op, mem_to_reg, alu_res, alu_res, pc_plus4, lu_data);

  assign MEM_WB_RdData   = MEM_WB[31:0];
  assign MEM_WB_Rd       = MEM_WB[36:32];
  assign MEM_WB_RegWrite = MEM_WB[37];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (access & aligned & ~mem_ack) begin
          state_nxt = WAIT;
          cnt_nxt   = 8'd1;
        end
      end
      WAIT: begin
        if (mem_ack || cnt == ACK_TIMEOUT) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // MEM -> WB boundary: stalls insert bubbles, failed accesses drop the register write.
  always_ff @(posedge clk) begin
    if (reset) begin
      MEM_WB    <= 38'b0;
      bus_error <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      MEM_WB    <= mem_stall ? 38'b0 : {reg_write_eff, write_reg, wb_data};
      bus_error <= timeout;
      misalign  <= misal;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model tracks how long each
// access has been outstanding and predicts handshake, stall and write-back results.
module tb_mem_stage;

  localparam logic [7:0] TO = 8'd4;

  logic         clk = 1'b0;
  logic         reset;
  logic [138:0] EX_MEM;
  logic         mem_req, mem_we, mem_ack, mem_stall;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [4:0]   EX_MEM_Rd, MEM_WB_Rd;
  logic [31:0]  EX_MEM_RdData, MEM_WB_RdData;
  logic         EX_MEM_RegWrite, MEM_WB_RegWrite;
  logic [37:0]  MEM_WB;
  logic         bus_error, misalign;

  int n_chk  = 0;
  int n_fail = 0;
  int pend   = 0;   // cycles the current access has already waited

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .EX_MEM(EX_MEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RdData(EX_MEM_RdData), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .MEM_WB(MEM_WB), .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RdData(MEM_WB_RdData),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .bus_error(bus_error), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [138:0] mk(input logic rd, input logic wr, input logic rw,
                                      input logic [1:0] mtr, input logic [4:0] wreg,
                                      input logic [31:0] alu, input logic [31:0] sd,
                                      input logic [31:0] pc4, input logic [31:0] lud,
                                      input logic luop);
    return {luop, lud, pc4, mtr, rw, wr, rd, wreg, alu, sd};
  endfunction

  function automatic logic [31:0] pick(input logic [138:0] ex, input logic [31:0] rdat);
    if (ex[138]) return ex[137:106];
    if (ex[73:72] == 2'd0) return ex[63:32];
    if (ex[73:72] == 2'd1) return rdat;
    if (ex[73:72] == 2'd2) return ex[105:74];
    return 32'h0;
  endfunction

  // One clock: check combinational outputs mid-cycle, then registered results after the edge.
  task automatic run_cycle(output logic st);
    logic acc, al, mis, ack, tmo;
    logic [37:0] exp_wb;
    @(negedge clk);
    acc = EX_MEM[69] | EX_MEM[70];
    al  = (EX_MEM[33:32] == 2'b00);
    mis = acc & ~al;
    ack = mem_ack;
    tmo = acc & al & ~ack & (pend == int'(TO));
    st  = acc & al & ~ack & ~tmo;
    chk("mem_req",   mem_req,   acc & al);
    chk("mem_stall", mem_stall, st);
    chk("mem_we",    mem_we,    EX_MEM[70]);
    chk("mem_addr",  mem_addr,  EX_MEM[63:32]);
    chk("mem_wdata", mem_wdata, EX_MEM[31:0]);
    chk("fwd_rd",    EX_MEM_Rd, EX_MEM[68:64]);
    chk("fwd_rw",    EX_MEM_RegWrite, EX_MEM[71] & ~EX_MEM[69]);
    chk("fwd_data",  EX_MEM_RdData, pick(EX_MEM, EX_MEM[63:32]));
    exp_wb = st ? 38'b0 : {EX_MEM[71] & ~tmo & ~mis, EX_MEM[68:64], pick(EX_MEM, ack ? mem_rdata : 32'h0)};
    pend = st ? pend + 1 : 0;
    @(posedge clk);
    #1;
    chk("mem_wb",    MEM_WB, exp_wb);
    chk("wb_slices", {MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_RdData}, exp_wb);
    chk("bus_error", bus_error, tmo);
    chk("misalign",  misalign, mis);
  endtask

  // Present one EX_MEM entry and hold it until the stage stops stalling.
  task automatic do_txn(input logic [138:0] ex, input int ack_dly, input logic [31:0] rdat,
                        output int stalls);
    logic st;
    logic req;
    stalls = 0;
    EX_MEM = ex;
    req = (ex[69] | ex[70]) & (ex[33:32] == 2'b00);
    for (int c = 0; c < 20; c++) begin
      mem_ack   = req && (c == ack_dly);
      mem_rdata = (c == ack_dly) ? rdat : $urandom;
      run_cycle(st);
      if (!st) break;
      stalls++;
      if (c == 19) chk("txn_bound", 1'b1, 1'b0);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    int s;
    logic st;
    reset = 1'b1;
    EX_MEM = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_wb",  MEM_WB, 38'b0);
    chk("rst_bus_err", bus_error, 1'b0);
    chk("rst_misal",   misalign, 1'b0);
    chk("rst_stall",   mem_stall, 1'b0);
    reset = 1'b0;

    do_txn(mk(0, 0, 1, 2'd0, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 0), 0, 32'h0, s);
    chk("alu_wb", MEM_WB, {1'b1, 5'd5, 32'h1234});

    do_txn(mk(1, 0, 1, 2'd1, 5'd7, 32'h10, 32'h0, 32'h0, 32'h0, 0), 3, 32'hCAFEBABE, s);
    chk("load_stalls", s, 3);
    chk("load_wb", MEM_WB, {1'b1, 5'd7, 32'hCAFEBABE});

    do_txn(mk(0, 1, 0, 2'd0, 5'd0, 32'h20, 32'h55, 32'h0, 32'h0, 0), 0, 32'h0, s);
    chk("store_stalls", s, 0);
    chk("store_rw", MEM_WB_RegWrite, 1'b0);

    do_txn(mk(1, 0, 1, 2'd1, 5'd9, 32'h40, 32'h0, 32'h0, 32'h0, 0), 99, 32'h0, s);
    chk("tmo_stalls", s, 4);
    chk("tmo_rw", MEM_WB_RegWrite, 1'b0);

    do_txn(mk(1, 0, 1, 2'd1, 5'd9, 32'h44, 32'h0, 32'h0, 32'h0, 0), 4, 32'h600D, s);
    chk("ack_wins_wb", MEM_WB, {1'b1, 5'd9, 32'h600D});

    do_txn(mk(1, 0, 1, 2'd1, 5'd3, 32'h13, 32'h0, 32'h0, 32'h0, 0), 0, 32'h0, s);
    chk("misal_stalls", s, 0);
    chk("misal_rw", MEM_WB_RegWrite, 1'b0);

    // Reset in the middle of a pending load.
    EX_MEM = mk(1, 0, 1, 2'd1, 5'd4, 32'h80, 32'h0, 32'h0, 32'h0, 0);
    run_cycle(st);
    run_cycle(st);
    reset = 1'b1;
    EX_MEM = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend = 0;
    chk("rstw_mem_wb", MEM_WB, 38'b0);
    chk("rstw_bus_err", bus_error, 1'b0);
    do_txn(mk(1, 0, 1, 2'd1, 5'd4, 32'h84, 32'h0, 32'h0, 32'h0, 0), 99, 32'h0, s);
    chk("rstw_tmo_stalls", s, 4);

    do_txn(mk(0, 0, 1, 2'd0, 5'd6, 32'h1, 32'h0, 32'h0, 32'hABCD0000, 1), 0, 32'h0, s);
    chk("lui_wb", MEM_WB_RdData, 32'hABCD0000);

    for (int i = 0; i < 300; i++) begin
      logic [138:0] ex;
      ex = {$urandom, $urandom, $urandom, $urandom, $urandom};
      ex[69] = ($urandom_range(0, 2) == 0);
      ex[70] = ~ex[69] & ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) ex[33:32] = 2'b00;
      do_txn(ex, $urandom_range(0, 6), $urandom, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
